mux_sel_pipe: RTL and testbench

//   Parametrised N-way WIDTH-bit selector with a registered, valid/ready-handshaked output stage.

---
 rtl/mux_sel_pipe.sv | 115 +++++++++++
 tb/tb_mux_sel_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_pipe.sv
// N-way WIDTH-bit selector feeding a registered valid/ready output stage with a 2-entry skid buffer.
// Optional macro MUX_SEL_PIPE_SEL_ERR_EN: out-of-range selects produce a zero word flagged by sel_err.
module mux_sel_pipe #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [NUM_IN-1:0] hit;
    logic [WIDTH-1:0]  word [NUM_IN];
    logic [WIDTH-1:0]  sel_word;
    logic [WIDTH-1:0]  new_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_in
            assign hit[gi]  = (sel == SEL_W'(gi));
            assign word[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Priority chain; an unmatched select falls through to the last input.
    always_comb begin
        sel_word = word[NUM_IN-1];
        for (int k = 0; k < NUM_IN; k++) begin
            if (hit[k]) sel_word = word[k];
        end
    end

    logic main_valid_reg, skid_valid_reg;
    logic [WIDTH-1:0] main_data_reg, skid_data_reg;
    logic accept, take;
    logic main_load_new, main_load_skid, skid_load;

    assign accept = in_valid & in_ready;
    assign take   = main_valid_reg & out_ready;

    // While the skid holds a word in_ready is low, so accept and skid drain never coincide.
    always_comb begin
        main_load_new  = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (skid_valid_reg) begin
            main_load_skid = take;
        end else if (accept) begin
            if (!main_valid_reg || take) main_load_new = 1'b1;
            else                         skid_load     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
        end else begin
            if (main_load_new) begin
                main_data_reg  <= new_data;
                main_valid_reg <= 1'b1;
            end else if (main_load_skid) begin
                main_data_reg  <= skid_data_reg;
            end else if (take) begin
                main_valid_reg <= 1'b0;
            end
            if (skid_load) begin
                skid_data_reg  <= new_data;
                skid_valid_reg <= 1'b1;
            end else if (main_load_skid) begin
                skid_valid_reg <= 1'b0;
            end
        end
    end

`ifdef MUX_SEL_PIPE_SEL_ERR_EN
    logic sel_bad;
    logic main_err_reg, skid_err_reg;

    assign sel_bad  = ~|hit;
    assign new_data = sel_bad ? '0 : sel_word;

    // The error flag rides alongside its word through both registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_err_reg <= 1'b0;
            skid_err_reg <= 1'b0;
        end else begin
            if (main_load_new)       main_err_reg <= sel_bad;
            else if (main_load_skid) main_err_reg <= skid_err_reg;
            if (skid_load)           skid_err_reg <= sel_bad;
        end
    end

    assign sel_err = main_err_reg;
`else
    assign new_data = sel_word;
    assign sel_err  = 1'b0;
`endif

    assign in_ready  = ~skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: directed stream/stall/hold/reset vectors, a NUM_IN=3 select check,
// and a random handshake run; a monitor pops expected words whenever the consumer takes one.
`timescale 1ns/1ps
module tb_mux_sel_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] in_data   = '0;
    logic [1:0]   sel       = '0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         sel_err;

    logic [95:0]  in_data3   = '0;
    logic [1:0]   sel3       = '0;
    logic         in_valid3  = 1'b0;
    logic         in_ready3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_ready3 = 1'b1;
    logic         sel_err3;

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .sel_err(sel_err3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Offer one word and keep it up until accepted; expected word is pushed at accept.
    task automatic send(input logic [1:0] s, input logic [127:0] d);
        int n = 0;
        in_valid = 1'b1;
        sel      = s;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready got 0 for 50 cycles, required 1");
        end else begin
            sb.push_back({1'b0, d[s*32 +: 32]});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every take is compared against the head of the scoreboard.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got word 0x%08h, required no word", out_data);
                end else begin
                    e = sb.pop_front();
                    $display("take data=0x%08h err=%0b exp=0x%08h", out_data, sel_err, e[31:0]);
                    chk("out_data", out_data, e[31:0]);
                    chk("sel_err", 32'(sel_err), 32'(e[32]));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [127:0] d_stream, d_stall;
    logic [31:0]  exp3;
    logic         exp_err3;
    logic         rnd_done;

    initial begin
        d_stream = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        d_stall  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stream: A,B,C,D back to back with no bubbles
        out_ready = 1'b1;
        fork
            begin
                send(2'd0, d_stream);
                send(2'd1, d_stream);
                send(2'd2, d_stream);
                send(2'd3, d_stream);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                for (int i = 0; i < 4; i++) begin
                    chk("stream_valid", 32'(out_valid), 32'd1);
                    @(negedge clk);
                end
            end
        join
        @(posedge clk);
        #1;

        // Stall: two words fill main and skid
        out_ready = 1'b0;
        send(2'd1, d_stall);
        send(2'd2, d_stall);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);

        // Hold: input churn must not disturb the held word
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            sel     = 2'(i);
            @(negedge clk);
            chk("hold_data", out_data, 32'h1111_1111);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-transfer with the skid full
        out_ready = 1'b0;
        send(2'd0, d_stream);
        send(2'd3, d_stream);
        @(negedge clk);
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);

        // NUM_IN=3: out-of-range and in-range selects
        @(posedge clk);
        #1;
        in_data3  = {32'hC3C3_C3C3, 32'hB3B3_B3B3, 32'hA3A3_A3A3};
        sel3      = 2'd3;
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
`ifdef MUX_SEL_PIPE_SEL_ERR_EN
        exp3 = 32'h0000_0000;
        exp_err3 = 1'b1;
`else
        exp3 = 32'hC3C3_C3C3;
        exp_err3 = 1'b0;
`endif
        @(negedge clk);
        chk("n3_sel3_valid", 32'(out_valid3), 32'd1);
        chk("n3_sel3_data", out_data3, exp3);
        chk("n3_sel3_err", 32'(sel_err3), 32'(exp_err3));
        @(posedge clk);
        #1;
        sel3      = 2'd1;
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        @(negedge clk);
        chk("n3_sel1_data", out_data3, 32'hB3B3_B3B3);
        chk("n3_sel1_err", 32'(sel_err3), 32'd0);

        // Random valid/ready traffic against the scoreboard
        @(posedge clk);
        #1;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom});
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        begin
            int n = 0;
            while (sb.size() > 0 && n < 100) begin
                n++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
